store_drain: RTL and testbench

STORE_DRAIN -- requirements
Module: store_drain

---
 rtl/store_drain.sv | 138 +++++++++++++
 tb/tb_store_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain.sv
// Store drain: pops committed stores from the store buffer head and issues
// them one at a time as SRAM-like writes to the dcache.
module store_drain #(
    parameter int STORE_GROUP = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          rob_commit_store,
    output logic                          commit_store_valid,
    input  logic [3:0]                    commit_store_wstrb,
    input  logic [2:0]                    commit_store_size,
    input  logic [31:0]                   commit_store_addr,
    input  logic [31:0]                   commit_store_data,
    output logic                          data_req,
    output logic                          data_wr,
    output logic [1:0]                    data_size,
    output logic [31:0]                   data_addr,
    output logic [3:0]                    data_wstrb,
    output logic [31:0]                   data_wdata,
    input  logic                          data_addr_ok,
    input  logic                          data_data_ok,
    output logic                          drain_busy,
    output logic [$clog2(STORE_GROUP):0]  pending_cnt
);

    localparam int CNT_W = $clog2(STORE_GROUP) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               pop;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [3:0]         wstrb_p1;
    logic [1:0]         size_p1;
    logic [31:0]        addr_p1;
    logic [31:0]        wdata_p1;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical memory.
    function automatic logic [31:0] translate(input logic [31:0] va);
        if (va[31:30] == 2'b10) begin
            return {3'b000, va[28:0]};
        end
        return va;
    endfunction

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (pending_cnt != '0) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    if (pending_cnt != '0) begin
                        pop       = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Flush discards the pending count but a same-cycle commit still counts.
    always_comb begin
        cnt_nxt = pending_cnt;
        if (flush) begin
            cnt_nxt = {{(CNT_W-1){1'b0}}, rob_commit_store};
        end else if (rob_commit_store && !pop) begin
            if (pending_cnt != CNT_W'(STORE_GROUP)) begin
                cnt_nxt = pending_cnt + 1'b1;
            end
        end else if (!rob_commit_store && pop) begin
            cnt_nxt = pending_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending_cnt <= '0;
        end else begin
            state       <= state_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    // Capture stage: head entry is latched in the same cycle it is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstrb_p1 <= '0;
            size_p1  <= '0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else if (pop) begin
            wstrb_p1 <= commit_store_wstrb;
            size_p1  <= commit_store_size[1:0];
            addr_p1  <= commit_store_addr;
            wdata_p1 <= commit_store_data;
        end
    end

    assign commit_store_valid = pop;
    assign data_req           = (state == REQ);
    assign data_wr            = (state == REQ);
    assign data_size          = size_p1;
    assign data_addr          = translate(addr_p1);
    assign data_wstrb         = wstrb_p1;
    assign data_wdata         = wdata_p1;
    assign drain_busy         = (state != IDLE) || (pending_cnt != '0);

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        (rob_commit_store && !flush && !pop) |-> (pending_cnt != CNT_W'(STORE_GROUP)));

    size_chk: assert property (@(posedge clk) disable iff (reset)
        pop |-> (commit_store_size <= 3'd2));

endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: directed scenarios plus random traffic, all checked
// against a queue-based store-buffer / single-outstanding-write model.
module tb_store_drain;

    localparam int SG = 16;
    localparam int CW = $clog2(SG) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic [2:0]  size;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          rob_commit_store = 1'b0;
    logic          commit_store_valid;
    logic [3:0]    commit_store_wstrb = '0;
    logic [2:0]    commit_store_size = '0;
    logic [31:0]   commit_store_addr = '0;
    logic [31:0]   commit_store_data = '0;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr;
    logic [3:0]    data_wstrb;
    logic [31:0]   data_wdata;
    logic          data_addr_ok = 1'b0;
    logic          data_data_ok = 1'b0;
    logic          drain_busy;
    logic [CW-1:0] pending_cnt;

    store_drain #(.STORE_GROUP(SG)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rob_commit_store(rob_commit_store),
        .commit_store_valid(commit_store_valid),
        .commit_store_wstrb(commit_store_wstrb),
        .commit_store_size(commit_store_size),
        .commit_store_addr(commit_store_addr),
        .commit_store_data(commit_store_data),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .drain_busy(drain_busy), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    // Model: q is the set of committed-but-not-popped stores; one write in flight.
    ent_t q[$];
    ent_t cap;
    bit   txn;
    bit   acked;
    int   checks = 0;
    int   failures = 0;
    int   step = 0;
    int   n_pop = 0;
    int   n_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, step, obs, exp);
        end
    endtask

    function automatic logic [31:0] xlate(input logic [31:0] a);
        logic [2:0] seg;
        seg = a[31:29];
        if (seg == 3'b100 || seg == 3'b101) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.addr  = $urandom;
        case ($urandom_range(0, 3))
            0: e.addr[31:29] = 3'b100;
            1: e.addr[31:29] = 3'b101;
            2: e.addr[31:29] = 3'b010;
            default: ;
        endcase
        e.data  = $urandom;
        e.wstrb = 4'($urandom_range(0, 15));
        e.size  = 3'($urandom_range(0, 2));
        return e;
    endfunction

    task automatic cycle(input bit c, input bit f, input bit aok, input bit dok, input ent_t e);
        ent_t head;
        bit   exp_pop;
        step++;
        rob_commit_store = c;
        flush            = f;
        data_addr_ok     = aok;
        data_data_ok     = dok;
        if (q.size() > 0) head = q[0];
        else begin
            head = rand_ent();
        end
        commit_store_addr  = head.addr;
        commit_store_data  = head.data;
        commit_store_wstrb = head.wstrb;
        commit_store_size  = head.size;
        #1;
        exp_pop = (q.size() > 0) && (!txn || (acked && dok));
        chk("pop",     32'(commit_store_valid), 32'(exp_pop));
        chk("req",     32'(data_req), 32'(txn && !acked));
        chk("wr",      32'(data_wr), 32'(txn && !acked));
        chk("pending", 32'(pending_cnt), 32'(q.size()));
        chk("busy",    32'(drain_busy), 32'(txn || q.size() != 0));
        chk("addr",    data_addr, xlate(cap.addr));
        chk("wdata",   data_wdata, cap.data);
        chk("wstrb",   32'(data_wstrb), 32'(cap.wstrb));
        chk("size",    32'(data_size), 32'(cap.size[1:0]));
        if (commit_store_valid === 1'b1) n_pop++;
        if (data_req === 1'b1 && aok) n_acc++;
        if (txn && acked && dok) txn = 1'b0;
        else if (txn && !acked && aok) acked = 1'b1;
        if (exp_pop) begin
            cap   = q.pop_front();
            txn   = 1'b1;
            acked = 1'b0;
        end
        if (f) q.delete();
        if (c) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        rob_commit_store = 1'b0;
        flush            = 1'b0;
        data_addr_ok     = 1'b0;
        data_data_ok     = 1'b0;
        #1;
    endtask

    task automatic idle(input bit aok, input bit dok);
        cycle(1'b0, 1'b0, aok, dok, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog step=%0d", step);
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e;
        int   p0;
        int   a0;
        int   budget;
        bit   c, aok, dok, f;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_pop",  32'(commit_store_valid), 32'd0);
        chk("rst_req",  32'(data_req), 32'd0);
        chk("rst_wr",   32'(data_wr), 32'd0);
        chk("rst_busy", 32'(drain_busy), 32'd0);
        chk("rst_cnt",  32'(pending_cnt), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_data", data_wdata, 32'd0);
        chk("rst_strb", 32'(data_wstrb), 32'd0);
        chk("rst_size", 32'(data_size), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        cap = '0;
        txn = 1'b0;
        acked = 1'b0;
        #1;

        // Single kseg0 store
        e.addr = 32'h8000_0010; e.data = 32'hDEAD_BEEF; e.wstrb = 4'hF; e.size = 3'd2;
        p0 = n_pop;
        cycle(1, 0, 0, 0, e);
        idle(0, 0);
        chk("s1_req",  32'(data_req), 32'd1);
        chk("s1_addr", data_addr, 32'h0000_0010);
        chk("s1_size", 32'(data_size), 32'd2);
        chk("s1_data", data_wdata, 32'hDEAD_BEEF);
        idle(1, 0);
        idle(0, 0);
        idle(0, 1);
        chk("s1_busy", 32'(drain_busy), 32'd0);
        chk("s1_pops", 32'(n_pop - p0), 32'd1);

        // Three back-to-back commits
        p0 = n_pop;
        a0 = n_acc;
        cycle(1, 0, 0, 0, rand_ent());
        cycle(1, 0, 0, 0, rand_ent());
        cycle(1, 0, 1, 0, rand_ent());
        chk("s3_cnt", 32'(pending_cnt), 32'd2);
        idle(0, 1);
        idle(1, 0);
        idle(0, 1);
        idle(1, 0);
        idle(0, 1);
        chk("s3_pops", 32'(n_pop - p0), 32'd3);
        chk("s3_reqs", 32'(n_acc - a0), 32'd3);
        chk("s3_busy", 32'(drain_busy), 32'd0);

        // Long addr_ok stall on a kseg1 store
        e.addr = 32'hA000_1234; e.data = 32'h1357_9BDF; e.wstrb = 4'h3; e.size = 3'd1;
        p0 = n_pop;
        cycle(1, 0, 0, 0, e);
        idle(0, 0);
        repeat (10) idle(0, 0);
        chk("st_req",  32'(data_req), 32'd1);
        chk("st_addr", data_addr, 32'h0000_1234);
        chk("st_pops", 32'(n_pop - p0), 32'd1);
        idle(1, 0);
        idle(0, 1);

        // Flush while waiting for data_ok with two pending
        p0 = n_pop;
        cycle(1, 0, 0, 0, rand_ent());
        cycle(1, 0, 0, 0, rand_ent());
        cycle(1, 0, 1, 0, rand_ent());
        chk("fl_cnt2", 32'(pending_cnt), 32'd2);
        cycle(0, 1, 0, 0, '0);
        chk("fl_cnt0", 32'(pending_cnt), 32'd0);
        chk("fl_busy", 32'(drain_busy), 32'd1);
        idle(0, 1);
        idle(0, 0);
        chk("fl_idle", 32'(drain_busy), 32'd0);
        chk("fl_pops", 32'(n_pop - p0), 32'd1);

        // Commit coincident with pop, untranslated address
        e.addr = 32'h4000_0000; e.data = 32'h0BAD_F00D; e.wstrb = 4'h1; e.size = 3'd0;
        cycle(1, 0, 0, 0, e);
        cycle(1, 0, 0, 0, rand_ent());
        chk("cp_cnt",  32'(pending_cnt), 32'd1);
        chk("cp_addr", data_addr, 32'h4000_0000);
        idle(1, 0);
        idle(0, 1);
        idle(1, 0);
        idle(0, 1);

        // Asynchronous reset in the middle of a request
        cycle(1, 0, 0, 0, rand_ent());
        idle(0, 0);
        chk("ar_pre", 32'(data_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_req",  32'(data_req), 32'd0);
        chk("ar_busy", 32'(drain_busy), 32'd0);
        chk("ar_cnt",  32'(pending_cnt), 32'd0);
        chk("ar_addr", data_addr, 32'd0);
        reset = 1'b0;
        q.delete();
        cap = '0;
        txn = 1'b0;
        acked = 1'b0;
        @(negedge clk);
        #1;
        idle(0, 0);
        idle(1, 1);

        // Random traffic: first a congested phase to fill the buffer
        for (int i = 0; i < 700; i++) begin
            if (i < 200) begin
                c   = (q.size() < SG) && ($urandom_range(0, 99) < 70);
                aok = ($urandom_range(0, 99) < 10);
                dok = ($urandom_range(0, 99) < 10);
            end else begin
                c   = (q.size() < SG) && ($urandom_range(0, 99) < 40);
                aok = ($urandom_range(0, 99) < 50);
                dok = ($urandom_range(0, 99) < 50);
            end
            f = ($urandom_range(0, 99) < 3);
            cycle(c, f, aok, dok, rand_ent());
        end

        budget = 200;
        while ((drain_busy !== 1'b0) && budget > 0) begin
            idle(1, 1);
            budget--;
        end
        chk("drain_done", 32'(drain_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
